// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - boot-time instruction memory loader with checksum and core hold
module inst_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accepting;
    logic        accept;
    logic [15:0] hdr_count;

    // Byte acceptance depends only on state (and reset), never on in_valid.
    always_comb begin
        accepting = (state_q == HDR0) || (state_q == HDR1) ||
                    (state_q == DATA) || (state_q == CSUM);
    end

    assign in_ready  = rst & accepting;
    assign accept    = in_valid & in_ready;
    assign hdr_count = {count_q[15:8], in_data};

    // Next-state, datapath and write-strobe computation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        word_d      = word_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (accept) begin
            // Every frame byte except the checksum itself feeds the running XOR.
            if (state_q != CSUM) begin
                csum_d = csum_q ^ in_data;
            end
            unique case (state_q)
                HDR0: begin
                    count_d = {in_data, 8'h00};
                    state_d = HDR1;
                end
                HDR1: begin
                    count_d = hdr_count;
                    if ({16'h0000, hdr_count} > 32'(DEPTH)) begin
                        state_d = ERR;
                    end else if (hdr_count == 16'h0000) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    lane_d = lane_q + 2'd1;
                    word_d = {word_q[15:0], in_data};
                    if (lane_q == 2'd3) begin
                        // Fourth byte completes the word: strobe it out next cycle.
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {word_q, in_data};
                        mem_addr_d  = BASE_ADDR + {14'h0000, idx_q, 2'b00};
                        idx_d       = idx_q + 16'd1;
                        if (idx_q + 16'd1 == count_q) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    state_d = (in_data == csum_q) ? RUN : ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers; asynchronous active-low reset abandons any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HDR0;
            count_q     <= 16'h0000;
            idx_q       <= 16'h0000;
            lane_q      <= 2'd0;
            word_q      <= 24'h000000;
            csum_q      <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = (state_q == RUN);
    assign err       = (state_q == ERR);
    assign cpu_hold  = (state_q != RUN);

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard testbench for inst_mem_loader
module tb_inst_mem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks;
    int errors;
    int we_cnt;
    logic [63:0] exp_q[$];

    inst_mem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .DEPTH(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        we_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the first nbytes of a frame; expected writes are pushed as each word's last byte goes out.
    task automatic send_frame(input logic [7:0] fr[$], input int nbytes, input int max_gap, input bit expect_wr);
        logic [31:0] w;
        for (int i = 0; i < nbytes; i++) begin
            if (expect_wr && i >= 2 && i < fr.size() - 1) begin
                w = {w[23:0], fr[i]};
                if ((i - 2) % 4 == 3) begin
                    exp_q.push_back({32'((i - 2) / 4 * 4), w});
                end
            end
            send_byte(fr[i], (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_final(input string tag, input logic d, input logic e, input int nwe);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_err"}, {31'd0, err}, {31'd0, e});
        check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, ~d});
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'(nwe));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] frame1[$];
    logic [7:0] frame_bad[$];
    logic [7:0] frame_empty[$];
    logic [7:0] frame_big[$];

    initial begin
        checks   = 0;
        errors   = 0;
        we_cnt   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        frame1      = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h22, 8'h00, 8'h05, 8'h39};
        frame_bad   = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h22, 8'h00, 8'h05, 8'h38};
        frame_empty = '{8'h00, 8'h00, 8'h00};
        frame_big   = '{8'h04, 8'h01};

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'h0000_0000);
        check("rst_wdata", mem_wdata, 32'h0000_0000);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        // Normal back-to-back load.
        send_frame(frame1, frame1.size(), 0, 1'b1);
        check_final("normal", 1'b1, 1'b0, 2);

        // Empty image.
        do_reset();
        send_frame(frame_empty, frame_empty.size(), 0, 1'b0);
        check_final("empty", 1'b1, 1'b0, 0);

        // Oversize count: error visible right after the second byte.
        do_reset();
        send_byte(frame_big[0], 0);
        send_byte(frame_big[1], 0);
        check("big_err_now", {31'd0, err}, 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_final("big", 1'b0, 1'b1, 0);

        // Bad checksum: writes still land, then error.
        do_reset();
        send_frame(frame_bad, frame_bad.size(), 0, 1'b1);
        check_final("badcs", 1'b0, 1'b1, 2);

        // Throttled source.
        do_reset();
        send_frame(frame1, frame1.size(), 3, 1'b1);
        check_final("throttle", 1'b1, 1'b0, 2);

        // Reset mid-load, asserted between edges.
        do_reset();
        send_frame(frame1, 5, 0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_ready", {31'd0, in_ready}, 32'd0);
        check("mid_we", {31'd0, mem_we}, 32'd0);
        check("mid_addr", mem_addr, 32'h0000_0000);
        check("mid_hold", {31'd0, cpu_hold}, 32'd1);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_err", {31'd0, err}, 32'd0);
        check("mid_we_cnt", 32'(we_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        we_cnt = 0;
        send_frame(frame1, frame1.size(), 0, 1'b1);
        check_final("reload", 1'b1, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
